// File: rtl/ramp_pkg.sv
// ramp_pkg: shared encodings for the ramp pattern generator.
//   mode_t  : run-mode codes as presented on the mode input
//   state_t : ramp controller states
//   Y*      : step-select codes, named after the default step size
package ramp_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP = 2'b00,
    MODE_SAT  = 2'b01,
    MODE_TRI  = 2'b10,
    MODE_RSVD = 2'b11   // decoded exactly like MODE_WRAP
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10,
    HOLD = 2'b11
  } state_t;

  localparam logic [1:0] Y0    = 2'b00;
  localparam logic [1:0] Y1    = 2'b01;
  localparam logic [1:0] Y16   = 2'b10;
  localparam logic [1:0] Y1290 = 2'b11;

endpackage

// File: rtl/ramp_step_lut.sv
// ramp_step_lut: combinational step-size table.
//   y    in  2       step select (Y0 always yields zero)
//   step out STEP_W  step magnitude for the selected code
module ramp_step_lut
  import ramp_pkg::*;
#(
  parameter int STEP_W = 11,
  parameter int STEP1  = 1,
  parameter int STEP2  = 16,
  parameter int STEP3  = 1290
) (
  input  logic [1:0]        y,
  output logic [STEP_W-1:0] step
);

  localparam logic [STEP_W-1:0] S1 = STEP_W'(STEP1);
  localparam logic [STEP_W-1:0] S2 = STEP_W'(STEP2);
  localparam logic [STEP_W-1:0] S3 = STEP_W'(STEP3);

  always_comb begin
    step = '0;
    case (y)
      Y1:      step = S1;
      Y16:     step = S2;
      Y1290:   step = S3;
      default: step = '0;
    endcase
  end

endmodule

// File: rtl/ramp_gen.sv
// ramp_gen: delta-stepped ramp generator with wrap, saturate and triangle modes.
//   clk      in   1      clock
//   rst      in   1      synchronous active-high reset
//   ramp_enb in   1      enable; low returns to IDLE and clears the ramp
//   delta    in   1      one step applied on every cycle it is high
//   Y        in   2      step select, sampled on every delta cycle
//   mode     in   2      run mode, captured on the IDLE->UP transition
//   out      out  WIDTH  ramp value
//   dir      out  1      high while descending (triangle)
//   turn_p   out  1      single-cycle pulse on wrap or triangle turnaround
//   sat      out  1      high while holding at MAX_VAL (saturate)
//   busy     out  1      high whenever not IDLE
module ramp_gen
  import ramp_pkg::*;
#(
  parameter int WIDTH   = 12,
  parameter int MAX_VAL = 4095,
  parameter int STEP_W  = 11,
  parameter int STEP1   = 1,
  parameter int STEP2   = 16,
  parameter int STEP3   = 1290
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ramp_enb,
  input  logic             delta,
  input  logic [1:0]       Y,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] out,
  output logic             dir,
  output logic             turn_p,
  output logic             sat,
  output logic             busy
);

  typedef logic [WIDTH:0]   sum_t;
  typedef logic [WIDTH-1:0] val_t;

  localparam val_t MAX_V = val_t'(MAX_VAL);
  localparam sum_t MAX_S = sum_t'(MAX_VAL);

  state_t state_reg, state_next;
  mode_t  mode_reg,  mode_next;
  val_t   out_reg,   out_next;
  logic   dir_reg,   dir_next;
  logic   turn_reg,  turn_next;
  logic   sat_reg,   sat_next;

  logic [STEP_W-1:0] step_raw;
  val_t              step_v;
  sum_t              sum;
  val_t              diff;
  logic              step_live;

  ramp_step_lut #(
    .STEP_W (STEP_W),
    .STEP1  (STEP1),
    .STEP2  (STEP2),
    .STEP3  (STEP3)
  ) u_lut (
    .y    (Y),
    .step (step_raw)
  );

  // One extra bit on the sum carries the wrap indication and lets the
  // saturate/triangle compare see overshoot past MAX_VAL.
  assign step_v    = val_t'(step_raw);
  assign sum       = sum_t'(out_reg) + sum_t'(step_v);
  assign diff      = out_reg - step_v;
  // A zero step must never move the value or fire a turnaround.
  assign step_live = delta && (step_raw != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      mode_reg  <= MODE_WRAP;
      out_reg   <= '0;
      dir_reg   <= 1'b0;
      turn_reg  <= 1'b0;
      sat_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      mode_reg  <= mode_next;
      out_reg   <= out_next;
      dir_reg   <= dir_next;
      turn_reg  <= turn_next;
      sat_reg   <= sat_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    mode_next  = mode_reg;
    out_next   = out_reg;
    dir_next   = dir_reg;
    sat_next   = sat_reg;
    turn_next  = 1'b0;

    if (!ramp_enb) begin
      state_next = IDLE;
      out_next   = '0;
      dir_next   = 1'b0;
      sat_next   = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // delta is deliberately ignored on the enabling edge
          state_next = UP;
          mode_next  = mode_t'(mode);
          out_next   = '0;
          dir_next   = 1'b0;
          sat_next   = 1'b0;
        end
        UP: begin
          if (step_live) begin
            case (mode_reg)
              MODE_SAT: begin
                if (sum >= MAX_S) begin
                  out_next   = MAX_V;
                  state_next = HOLD;
                  sat_next   = 1'b1;
                end else begin
                  out_next = sum[WIDTH-1:0];
                end
              end
              MODE_TRI: begin
                if (sum >= MAX_S) begin
                  out_next   = MAX_V;
                  state_next = DOWN;
                  dir_next   = 1'b1;
                  turn_next  = 1'b1;
                end else begin
                  out_next = sum[WIDTH-1:0];
                end
              end
              default: begin
                // wrap and reserved: free-running modulo 2^WIDTH
                out_next  = sum[WIDTH-1:0];
                turn_next = sum[WIDTH];
              end
            endcase
          end
        end
        DOWN: begin
          if (step_live) begin
            if (out_reg <= step_v) begin
              out_next   = '0;
              state_next = UP;
              dir_next   = 1'b0;
              turn_next  = 1'b1;
            end else begin
              out_next = diff;
            end
          end
        end
        HOLD: begin
          // frozen until enable drops or reset
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign out    = out_reg;
  assign dir    = dir_reg;
  assign turn_p = turn_reg;
  assign sat    = sat_reg;
  assign busy   = (state_reg != IDLE);

endmodule
